// File: rtl/dw_rnd_pkg.sv
// Shared rounding-mode codes and sequencer state encoding for the
// normalize/round and denormalize/round blocks.
package dw_rnd_pkg;

    localparam logic [2:0] RND_RNE = 3'b000;
    localparam logic [2:0] RND_RTZ = 3'b001;
    localparam logic [2:0] RND_RPI = 3'b010;
    localparam logic [2:0] RND_RMI = 3'b011;
    localparam logic [2:0] RND_RUP = 3'b100;
    localparam logic [2:0] RND_RAZ = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } rnd_state_t;

endpackage

// File: rtl/dw_rnd_inc.sv
// Rounding increment decision, W-bit incrementer and saturation on carry-out.
module dw_rnd_inc
    import dw_rnd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] mag,
    input  logic         sign,
    input  logic         round,
    input  logic         sticky,
    input  logic [2:0]   rnd_mode,
    output logic [W-1:0] res,
    output logic         ovfl
);

    logic         inc;
    logic [W:0]   sum;

    always_comb begin
        inc = 1'b0;
        case (rnd_mode)
            RND_RNE: inc = round & (sticky | mag[0]);
            RND_RPI: inc = ~sign & (round | sticky);
            RND_RMI: inc = sign & (round | sticky);
            RND_RUP: inc = round;
            RND_RAZ: inc = round | sticky;
            default: inc = 1'b0;
        endcase
        sum  = {1'b0, mag} + (W+1)'(inc);
        ovfl = sum[W];
        res  = sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

endmodule

// File: rtl/dw_denorm_rnd_seq.sv
// Iterative denormalizer: right-shifts a 1.f mantissa into a fixed-point magnitude,
// tracking round/sticky. Rounding stage is built only when DW_DENORM_RND_EN is defined.
module dw_denorm_rnd_seq
    import dw_rnd_pkg::*;
#(
    parameter int b_width    = 10,
    parameter int a_width    = 16,
    parameter int exp_width  = 4,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [b_width-1:0]   b,
    input  logic                 b_sign,
    input  logic [exp_width-1:0] pos,
    input  logic                 sticky_bit,
    input  logic [2:0]           rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [a_width-1:0]   a_mag,
    output logic                 a_sign,
    output logic                 inexact,
    output logic                 ovfl,
    output logic [1:0]           dbg_state
);

    localparam int REM_W = $clog2(a_width + 1);
    localparam int PAD   = a_width - b_width;

    // Handshake: a transfer happens on a rising edge where valid && ready; out_valid and
    // the result stay constant until out_ready is seen, and in_ready is high only in IDLE.
    rnd_state_t         state;
    logic [a_width-1:0] sr;
    logic [REM_W-1:0]   rem;
    logic               rnd_r;
    logic               stk_r;

    logic [REM_W-1:0]   pos_clip;
    logic [REM_W-1:0]   step_k;
    logic [a_width-1:0] sr_shift;
    logic               rnd_next;
    logic               lo_or;

    always_comb begin
        pos_clip = REM_W'(a_width);
        if (32'(pos) < 32'(a_width)) pos_clip = REM_W'(pos);
        step_k = rem;
        if (rem > REM_W'(SHIFT_STEP)) step_k = REM_W'(SHIFT_STEP);
        sr_shift = sr >> step_k;
        rnd_next = 1'b0;
        lo_or    = 1'b0;
        for (int i = 0; i < a_width; i++) begin
            if (i == int'(step_k) - 1) rnd_next = sr[i];
            if (i < int'(step_k) - 1)  lo_or = lo_or | sr[i];
        end
    end

`ifdef DW_DENORM_RND_EN
    logic [2:0]         mode_r;
    logic               ovfl_r;
    logic [a_width-1:0] inc_res;
    logic               inc_ovfl;

    dw_rnd_inc #(.W(a_width)) u_inc (
        .mag      (sr),
        .sign     (a_sign),
        .round    (rnd_r),
        .sticky   (stk_r),
        .rnd_mode (mode_r),
        .res      (inc_res),
        .ovfl     (inc_ovfl)
    );
    assign ovfl = ovfl_r;
`else
    wire unused_rnd_mode = &{1'b0, rnd_mode};
    assign ovfl = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            rem       <= '0;
            rnd_r     <= 1'b0;
            stk_r     <= 1'b0;
            a_sign    <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DW_DENORM_RND_EN
            mode_r    <= RND_RTZ;
            ovfl_r    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        sr       <= a_width'(b) << PAD;
                        rem      <= pos_clip;
                        rnd_r    <= 1'b0;
                        stk_r    <= sticky_bit;
                        a_sign   <= b_sign;
                        in_ready <= 1'b0;
`ifdef DW_DENORM_RND_EN
                        mode_r   <= rnd_mode;
                        ovfl_r   <= 1'b0;
                        state    <= (pos_clip != '0) ? ST_SHIFT : ST_ROUND;
`else
                        if (pos_clip != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
`endif
                    end
                end
                ST_SHIFT: begin
                    sr    <= sr_shift;
                    rnd_r <= rnd_next;
                    stk_r <= stk_r | rnd_r | lo_or;
                    rem   <= rem - step_k;
                    if (rem == step_k) begin
`ifdef DW_DENORM_RND_EN
                        state <= ST_ROUND;
`else
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
`endif
                    end
                end
`ifdef DW_DENORM_RND_EN
                ST_ROUND: begin
                    sr        <= inc_res;
                    ovfl_r    <= inc_ovfl;
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign a_mag     = sr;
    assign inexact   = rnd_r | stk_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_dw_denorm_rnd_seq.sv
// Directed vector bench for dw_denorm_rnd_seq over three configurations
// (16/10 step 1, 10/10 step 1, 16/10 step 4); expectations follow DW_DENORM_RND_EN.
module tb_dw_denorm_rnd_seq;
    import dw_rnd_pkg::*;

`ifdef DW_DENORM_RND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid_v;
    logic [9:0]  b;
    logic        b_sign;
    logic [4:0]  pos;
    logic        sticky_bit;
    logic [2:0]  rnd_mode;
    logic        out_ready;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [15:0] a_mag0, a_mag2;
    logic [9:0]  a_mag1;
    logic        a_sign0, a_sign1, a_sign2;
    logic        inexact0, inexact1, inexact2;
    logic        ovfl0, ovfl1, ovfl2;
    logic [1:0]  st0, st1, st2;

    int          sel;
    logic        in_ready_s, out_valid_s, a_sign_s, inexact_s, ovfl_s;
    logic [15:0] a_mag_s;
    logic [1:0]  st_s;

    int total;
    int bad;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dw_denorm_rnd_seq #(.b_width(10), .a_width(16), .exp_width(5), .SHIFT_STEP(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready0), .b(b),
        .b_sign(b_sign), .pos(pos), .sticky_bit(sticky_bit), .rnd_mode(rnd_mode),
        .out_valid(out_valid0), .out_ready(out_ready), .a_mag(a_mag0), .a_sign(a_sign0),
        .inexact(inexact0), .ovfl(ovfl0), .dbg_state(st0)
    );

    dw_denorm_rnd_seq #(.b_width(10), .a_width(10), .exp_width(4), .SHIFT_STEP(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready1), .b(b),
        .b_sign(b_sign), .pos(pos[3:0]), .sticky_bit(sticky_bit), .rnd_mode(rnd_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .a_mag(a_mag1), .a_sign(a_sign1),
        .inexact(inexact1), .ovfl(ovfl1), .dbg_state(st1)
    );

    dw_denorm_rnd_seq #(.b_width(10), .a_width(16), .exp_width(4), .SHIFT_STEP(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready2), .b(b),
        .b_sign(b_sign), .pos(pos[3:0]), .sticky_bit(sticky_bit), .rnd_mode(rnd_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .a_mag(a_mag2), .a_sign(a_sign2),
        .inexact(inexact2), .ovfl(ovfl2), .dbg_state(st2)
    );

    always_comb begin
        in_ready_s  = in_ready0;
        out_valid_s = out_valid0;
        a_mag_s     = a_mag0;
        a_sign_s    = a_sign0;
        inexact_s   = inexact0;
        ovfl_s      = ovfl0;
        st_s        = st0;
        if (sel == 1) begin
            in_ready_s  = in_ready1;
            out_valid_s = out_valid1;
            a_mag_s     = {6'b0, a_mag1};
            a_sign_s    = a_sign1;
            inexact_s   = inexact1;
            ovfl_s      = ovfl1;
            st_s        = st1;
        end else if (sel == 2) begin
            in_ready_s  = in_ready2;
            out_valid_s = out_valid2;
            a_mag_s     = a_mag2;
            a_sign_s    = a_sign2;
            inexact_s   = inexact2;
            ovfl_s      = ovfl2;
            st_s        = st2;
        end
    end

    typedef struct {
        int          inst;
        logic [9:0]  b;
        logic        sgn;
        logic [4:0]  pos;
        logic        stk;
        logic [2:0]  mode;
        logic [15:0] mag_on;
        logic [15:0] mag_off;
        logic        ovfl_on;
        logic        inex;
    } vec_t;

    vec_t vecs[17];

    // scoreboard check
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int inst, input logic [4:0] p);
        int aw, step, pp, m;
        aw   = (inst == 1) ? 10 : 16;
        step = (inst == 2) ? 4 : 1;
        pp   = (inst == 0) ? int'(p) : int'(p[3:0]);
        m    = (pp < aw) ? pp : aw;
        return (m + step - 1) / step + 1 + (RND ? 1 : 0);
    endfunction

    // driver: issue one transaction, measure latency, check, optionally stall, then drain
    task automatic run_vec(input vec_t v, input int hold);
        int          cnt;
        logic [15:0] emag;
        emag       = RND ? v.mag_on : v.mag_off;
        sel        = v.inst;
        b          = v.b;
        b_sign     = v.sgn;
        pos        = v.pos;
        sticky_bit = v.stk;
        rnd_mode   = v.mode;
        in_valid_v = 3'b001 << v.inst;
        @(posedge clk); #1;
        in_valid_v = 3'b000;
        cnt = 1;
        check("in_ready_busy", 32'(in_ready_s), 32'd0);
        while (!out_valid_s && cnt < 60) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), 32'(exp_lat(v.inst, v.pos)));
        check("a_mag", 32'(a_mag_s), 32'(emag));
        check("a_sign", 32'(a_sign_s), 32'(v.sgn));
        check("inexact", 32'(inexact_s), 32'(v.inex));
        check("ovfl", 32'(ovfl_s), 32'(RND & v.ovfl_on));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid_s), 32'd1);
            check("stall_ready", 32'(in_ready_s), 32'd0);
            check("stall_mag", 32'(a_mag_s), 32'(emag));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid_s), 32'd0);
        check("drain_ready", 32'(in_ready_s), 32'd1);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        sel        = 0;
        rst        = 1'b1;
        in_valid_v = 3'b000;
        b          = '0;
        b_sign     = 1'b0;
        pos        = '0;
        sticky_bit = 1'b0;
        rnd_mode   = RND_RTZ;
        out_ready  = 1'b0;

        //             inst  b       sgn   pos    stk   mode     on       off      ov    inex
        vecs[0]  = '{0, 10'h200, 1'b0, 5'd3,  1'b0, RND_RTZ, 16'h1000, 16'h1000, 1'b0, 1'b0};
        vecs[1]  = '{0, 10'h3FF, 1'b0, 5'd7,  1'b0, RND_RNE, 16'h0200, 16'h01FF, 1'b0, 1'b1};
        vecs[2]  = '{0, 10'h3FF, 1'b0, 5'd7,  1'b0, RND_RTZ, 16'h01FF, 16'h01FF, 1'b0, 1'b1};
        vecs[3]  = '{0, 10'h3FF, 1'b0, 5'd7,  1'b0, RND_RMI, 16'h01FF, 16'h01FF, 1'b0, 1'b1};
        vecs[4]  = '{0, 10'h3FF, 1'b1, 5'd7,  1'b0, RND_RMI, 16'h0200, 16'h01FF, 1'b0, 1'b1};
        vecs[5]  = '{0, 10'h200, 1'b0, 5'd16, 1'b0, RND_RNE, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[6]  = '{0, 10'h200, 1'b0, 5'd16, 1'b0, RND_RAZ, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{0, 10'h200, 1'b0, 5'd15, 1'b0, RND_RNE, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{1, 10'h3FF, 1'b0, 5'd0,  1'b1, RND_RAZ, 16'h03FF, 16'h03FF, 1'b1, 1'b1};
        vecs[9]  = '{2, 10'h3FF, 1'b0, 5'd7,  1'b0, RND_RNE, 16'h0200, 16'h01FF, 1'b0, 1'b1};
        vecs[10] = '{2, 10'h3FF, 1'b1, 5'd7,  1'b0, RND_RMI, 16'h0200, 16'h01FF, 1'b0, 1'b1};
        vecs[11] = '{0, 10'h200, 1'b0, 5'd3,  1'b1, RND_RPI, 16'h1001, 16'h1000, 1'b0, 1'b1};
        vecs[12] = '{0, 10'h3FF, 1'b0, 5'd7,  1'b0, 3'b111,  16'h01FF, 16'h01FF, 1'b0, 1'b1};
        vecs[13] = '{0, 10'h3FF, 1'b1, 5'd7,  1'b0, RND_RPI, 16'h01FF, 16'h01FF, 1'b0, 1'b1};
        vecs[14] = '{0, 10'h3FF, 1'b0, 5'd20, 1'b0, RND_RNE, 16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[15] = '{1, 10'h155, 1'b1, 5'd0,  1'b0, RND_RNE, 16'h0155, 16'h0155, 1'b0, 1'b0};
        vecs[16] = '{2, 10'h2AB, 1'b0, 5'd9,  1'b0, RND_RAZ, 16'h0056, 16'h0055, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid_s), 32'd0);
        check("rst_in_ready", 32'(in_ready_s), 32'd1);
        check("rst_a_mag", 32'(a_mag_s), 32'd0);
        check("rst_inexact", 32'(inexact_s), 32'd0);
        check("rst_ovfl", 32'(ovfl_s), 32'd0);
        check("rst_a_sign", 32'(a_sign_s), 32'd0);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], 0);

        // output stall: result must stay put while out_ready is low
        run_vec(vecs[1], 4);

        // reset in the middle of a shift discards the transaction
        begin
            int seen;
            sel        = 0;
            b          = 10'h3FF;
            b_sign     = 1'b1;
            pos        = 5'd10;
            rnd_mode   = RND_RNE;
            in_valid_v = 3'b001;
            @(posedge clk); #1;
            in_valid_v = 3'b000;
            repeat (3) @(posedge clk);
            #1;
            check("mid_state", 32'(st_s), 32'(ST_SHIFT));
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_mid_valid", 32'(out_valid_s), 32'd0);
            check("rst_mid_ready", 32'(in_ready_s), 32'd1);
            check("rst_mid_state", 32'(st_s), 32'(ST_IDLE));
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                if (out_valid_s) seen++;
            end
            check("rst_no_output", 32'(seen), 32'd0);
        end

        // fresh transaction after the aborted one
        run_vec(vecs[2], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
